// File: rtl/kernel_pr_fifo_rr_merge.sv
// Round-robin merge of N FIFO read-side streams into one tagged FIFO write stream,
// with bounded burst hold and a registered output stage.
module kernel_pr_fifo_rr_merge #(
    parameter int N          = 4,
    parameter int TAG_W      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N-1:0]                in_empty_n,
    output logic [N-1:0]                in_read,
    input  logic [N*DATA_WIDTH-1:0]     in_dout,
    input  logic                        out_full_n,
    output logic                        out_write,
    output logic [TAG_W+DATA_WIDTH-1:0] out_din,
    input  logic                        cnt_clr,
    output logic [31:0]                 out_cnt,
    output logic                        busy
);

    // Handshake: a source word moves when in_read[i] & in_empty_n[i] (read strobe only
    // issued when not empty); a downstream word moves when out_write & out_full_n.
    typedef enum logic {ARB, HOLD} state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t                        state, nxt_state;
    logic [TAG_W-1:0]              ptr, nxt_ptr;
    logic [TAG_W-1:0]              cur, nxt_cur;
    logic [3:0]                    burst_cnt, nxt_burst;
    logic                          ov;
    logic [TAG_W+DATA_WIDTH-1:0]   dout_q;
    logic [1:0]                    run_q;
    logic                          run;
    logic                          rdy;
    logic                          xfer;
    logic [TAG_W-1:0]              start;
    logic                          sel_found;
    logic [TAG_W-1:0]              sel_idx;
    logic                          rd_en;
    logic [TAG_W-1:0]              rd_idx;
    logic [DATA_WIDTH-1:0]         rd_data;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] v);
        if (int'(v) == N - 1) return '0;
        return v + 1'b1;
    endfunction

    // Reads stay off until reset release has passed through two flops.
    assign run  = run_q[1];
    assign rdy  = ~ov | out_full_n;
    assign xfer = ov & out_full_n;

    // On a HOLD release the search restarts just past the current owner.
    assign start = (state == HOLD) ? wrap_inc(cur) : ptr;

    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!sel_found && in_empty_n[idx]) begin
                sel_found = 1'b1;
                sel_idx   = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        rd_en     = 1'b0;
        rd_idx    = cur;
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_cur   = cur;
        nxt_burst = burst_cnt;
        if (run && rdy) begin
            if (state == HOLD && in_empty_n[cur] && burst_cnt < MAX_B) begin
                rd_en     = 1'b1;
                rd_idx    = cur;
                nxt_burst = burst_cnt + 4'd1;
            end else begin
                if (state == HOLD) nxt_ptr = wrap_inc(cur);
                if (sel_found) begin
                    rd_en     = 1'b1;
                    rd_idx    = sel_idx;
                    nxt_cur   = sel_idx;
                    nxt_burst = 4'd1;
                    if (MAX_BURST > 1) begin
                        nxt_state = HOLD;
                    end else begin
                        nxt_state = ARB;
                        nxt_ptr   = wrap_inc(sel_idx);
                    end
                end else begin
                    nxt_state = ARB;
                end
            end
        end
    end

    always_comb begin
        in_read = '0;
        if (rd_en) in_read[rd_idx] = 1'b1;
    end

    assign rd_data = in_dout[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q     <= 2'b00;
            state     <= ARB;
            ptr       <= '0;
            cur       <= '0;
            burst_cnt <= 4'd0;
            ov        <= 1'b0;
            dout_q    <= '0;
            out_cnt   <= 32'd0;
        end else begin
            run_q     <= {run_q[0], 1'b1};
            state     <= nxt_state;
            ptr       <= nxt_ptr;
            cur       <= nxt_cur;
            burst_cnt <= nxt_burst;
            if (rd_en) begin
                dout_q <= {rd_idx, rd_data};
                ov     <= 1'b1;
            end else if (xfer) begin
                ov <= 1'b0;
            end
            // Clear takes priority over a same-cycle transfer.
            if (cnt_clr)   out_cnt <= 32'd0;
            else if (xfer) out_cnt <= out_cnt + 32'd1;
        end
    end

    assign out_write = ov;
    assign out_din   = dout_q;
    assign busy      = (state == HOLD) | ov;

endmodule
